// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic inter-stage pipeline register with a valid bit, a flush that wins
//   over stall, bubble insertion, and a registered feedback flag that goes
//   back to the upstream stage.
//
//   Optional feature macro: PIPE_STAGE_REG_PERF_CNT_EN
//     adds saturating BUBBLE/HOLD/FLUSH event counters with a synchronous clear.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   stall      global stall vector; bit STAGE = upstream, STAGE+1 = downstream
//   flush      kills this stage's contents
//   in_valid   upstream payload valid
//   in_data    upstream payload (DATA_W)
//   in_fb      upstream feedback flag
//   out_valid  registered valid
//   out_data   registered payload (NOP_VALUE when not valid)
//   out_fb     registered feedback flag, routed back upstream
//   perf_clr   (feature) synchronous counter clear
//   bubble_cnt (feature) BUBBLE edges seen, saturating
//   hold_cnt   (feature) HOLD edges seen, saturating
//   flush_cnt  (feature) FLUSH edges seen, saturating
module pipe_stage_reg #(
  parameter int unsigned         DATA_W    = 64,
  parameter int unsigned         STALL_W   = 6,
  parameter int unsigned         STAGE     = 2,
  parameter logic [DATA_W-1:0]   NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned         CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_fb,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_fb
`ifdef PIPE_STAGE_REG_PERF_CNT_EN
  ,
  input  logic               perf_clr,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  generate
    if (STAGE + 1 >= STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE+1 must be less than STALL_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } act_e;

  logic up;
  logic dn;
  act_e act;

  assign up = stall[STAGE];
  assign dn = stall[STAGE+1];

  // Remaining stall bits belong to other stages.
  logic unused_stall;
  assign unused_stall = ^stall;

  // up=0/dn=1 is outside the stall controller's contract; it falls through
  // to ADVANCE.
  always_comb begin
    act = ACT_ADVANCE;
    if (flush)          act = ACT_FLUSH;
    else if (up && !dn) act = ACT_BUBBLE;
    else if (up)        act = ACT_HOLD;
  end

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              fb_q,    fb_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    fb_d    = fb_q;
    case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        valid_d = 1'b0;
        data_d  = NOP_VALUE;
        fb_d    = 1'b0;
      end
      ACT_ADVANCE: begin
        valid_d = in_valid;
        data_d  = in_valid ? in_data : NOP_VALUE;
        fb_d    = in_fb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VALUE;
      fb_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      fb_q    <= fb_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_fb    = fb_q;

`ifdef PIPE_STAGE_REG_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] hold_q,   hold_d;
  logic [CNT_W-1:0] flush_q,  flush_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    bubble_d = bubble_q;
    hold_d   = hold_q;
    flush_d  = flush_q;
    if (perf_clr) begin
      bubble_d = '0;
      hold_d   = '0;
      flush_d  = '0;
    end else begin
      case (act)
        ACT_BUBBLE: bubble_d = sat_inc(bubble_q);
        ACT_HOLD:   hold_d   = sat_inc(hold_q);
        ACT_FLUSH:  flush_d  = sat_inc(flush_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
      hold_q   <= '0;
      flush_q  <= '0;
    end else begin
      bubble_q <= bubble_d;
      hold_q   <= hold_d;
      flush_q  <= flush_d;
    end
  end

  assign bubble_cnt = bubble_q;
  assign hold_cnt   = hold_q;
  assign flush_cnt  = flush_q;
`endif

`ifndef SYNTHESIS
  a_monotonic_stall: assert property (@(posedge clk) disable iff (rst) !(dn && !up))
    else $error("pipe_stage_reg: non-monotonic stall (up=0, dn=1)");
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int unsigned     DW  = 16;
  localparam int unsigned     CW  = 4;
  localparam logic [DW-1:0]   NOP = 16'hDEAD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    stall = '0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_fb = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_fb;
  logic          perf_clr = 1'b0;
`ifdef PIPE_STAGE_REG_PERF_CNT_EN
  logic [CW-1:0] bubble_cnt, hold_cnt, flush_cnt;
`endif

  pipe_stage_reg #(
    .DATA_W   (DW),
    .STALL_W  (6),
    .STAGE    (2),
    .NOP_VALUE(NOP),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_fb    (in_fb),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_fb   (out_fb)
`ifdef PIPE_STAGE_REG_PERF_CNT_EN
    ,
    .perf_clr  (perf_clr),
    .bubble_cnt(bubble_cnt),
    .hold_cnt  (hold_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          fb;
    logic [CW-1:0] b;
    logic [CW-1:0] h;
    logic [CW-1:0] f;
  } exp_t;

  exp_t sbq[$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  logic          m_v = 1'b0;
  logic [DW-1:0] m_d = NOP;
  logic          m_fb = 1'b0;
  logic [CW-1:0] m_b = '0, m_h = '0, m_f = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic model_reset();
    m_v = 1'b0; m_d = NOP; m_fb = 1'b0;
    m_b = '0; m_h = '0; m_f = '0;
  endtask

  task automatic cyc(input logic [5:0] s, input logic f, input logic v,
                     input logic [DW-1:0] d, input logic fb, input logic clr);
    logic up, dn;
    exp_t e;
    @(negedge clk);
    stall = s; flush = f; in_valid = v; in_data = d; in_fb = fb; perf_clr = clr;
    up = s[2];
    dn = s[3];
    if (f) begin
      m_v = 1'b0; m_d = NOP; m_fb = 1'b0; m_f = sat(m_f);
    end else if (up && !dn) begin
      m_v = 1'b0; m_d = NOP; m_fb = 1'b0; m_b = sat(m_b);
    end else if (!up) begin
      m_v = v; m_d = v ? d : NOP; m_fb = fb;
    end else begin
      m_h = sat(m_h);
    end
    if (clr) begin
      m_b = '0; m_h = '0; m_f = '0;
    end
    sbq.push_back('{m_v, m_d, m_fb, m_b, m_h, m_f});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'(1), 64'(0));
    end else begin
      e = sbq.pop_front();
      chk("valid", 64'(out_valid), 64'(e.v));
      chk("data",  64'(out_data),  64'(e.d));
      chk("fb",    64'(out_fb),    64'(e.fb));
`ifdef PIPE_STAGE_REG_PERF_CNT_EN
      chk("bubble_cnt", 64'(bubble_cnt), 64'(e.b));
      chk("hold_cnt",   64'(hold_cnt),   64'(e.h));
      chk("flush_cnt",  64'(flush_cnt),  64'(e.f));
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] s;
    int unsigned k;

    // Power-on reset
    #12;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data",  64'(out_data),  64'(NOP));
    chk("rst_fb",    64'(out_fb),    64'(0));
`ifdef PIPE_STAGE_REG_PERF_CNT_EN
    chk("rst_hold_cnt", 64'(hold_cnt), 64'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Advance, then an invalid beat becomes NOP
    cyc(6'b000000, 1'b0, 1'b1, 16'hA5A5, 1'b1, 1'b0);
    cyc(6'b000000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    // Bubble
    cyc(6'b000000, 1'b0, 1'b1, 16'h0055, 1'b0, 1'b0);
    cyc(6'b000111, 1'b0, 1'b1, 16'hAAAA, 1'b1, 1'b0);

    // Hold keeps payload and feedback flag
    cyc(6'b000000, 1'b0, 1'b1, 16'h0066, 1'b1, 1'b0);
    repeat (3) cyc(6'b001111, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);

    // Stall bits below STAGE do not affect this stage
    cyc(6'b000011, 1'b0, 1'b1, 16'h1357, 1'b1, 1'b0);

    // Flush beats hold
    cyc(6'b000000, 1'b0, 1'b1, 16'h0077, 1'b1, 1'b0);
    cyc(6'b001111, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b0);
    cyc(6'b001111, 1'b1, 1'b1, 16'h2222, 1'b1, 1'b0);

    // Long hold: counter saturation
    cyc(6'b000000, 1'b0, 1'b1, 16'h4242, 1'b1, 1'b0);
    repeat (20) cyc(6'b001111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Clear together with a bubble
    cyc(6'b000111, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b1);
    // Flush with every stall bit set
    cyc(6'b111111, 1'b1, 1'b1, 16'h4444, 1'b1, 1'b0);

    // Random legal (monotonic) traffic
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 6);
      s = 6'((7'd1 << k) - 7'd1);
      cyc(s, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
          DW'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset in mid-cycle while holding a valid payload
    cyc(6'b000000, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
    cyc(6'b001111, 1'b0, 1'b1, 16'h5678, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'(0));
    chk("async_rst_data",  64'(out_data),  64'(NOP));
    chk("async_rst_fb",    64'(out_fb),    64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(6'b001111, 1'b0, 1'b1, 16'h9ABC, 1'b1, 1'b0);
    cyc(6'b000000, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
